prng_arbiter: RTL
=================

PRNG_ARBITER -- requirements
Module: prng_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (range 2..16).
REQ-002 The block SHALL have parameter SEED, default 32'h0000_0001, giving the reset seed.
REQ-003 The block SHALL have parameter WARMUP_CYCLES, default 8, giving generator advances after seeding before grants (range 0..255).
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port enable_i, input, 1 bit: grants permitted when high.
REQ-007 The block SHALL have port seed_load_i, input, 1 bit: reseed strobe.
REQ-008 The block SHALL have port seed_i, input, 32 bits: the seed value, sampled with seed_load_i.
REQ-009 The block SHALL have port req_i, input, NUM_REQ bits: per-requester level request.
REQ-010 The block SHALL have port gnt_o, output, NUM_REQ bits: registered one-hot grant pulse.
REQ-011 The block SHALL have port data_o, output, 8 bits: random byte, valid while gnt_o is nonzero.
REQ-012 The block SHALL have port ready_o, output, 1 bit: high while in state RUN.

Function
REQ-013 The generator SHALL be a synthesizable 32-bit xorshift state S with next(S) computed in order: S^=S<<13; S^=S>>17; S^=S<<5; all truncated to 32 bits.
REQ-014 Any seed of zero (SEED or seed_i) SHALL be replaced by 32'hDEADBEEF; S SHALL never hold 0.
REQ-015 The FSM SHALL have three states: WARMUP, RUN and HOLD.
REQ-016 In WARMUP, S SHALL advance every cycle, with a counter counting WARMUP_CYCLES advances; the FSM SHALL then enter RUN (or HOLD if enable_i is low).
REQ-017 If WARMUP_CYCLES is 0, seeding SHALL go directly to RUN or HOLD.
REQ-018 RUN SHALL go to HOLD when enable_i is sampled low; HOLD SHALL go to RUN when enable_i is sampled high.
REQ-019 In HOLD, S SHALL be frozen and gnt_o SHALL be 0.
REQ-020 In RUN, the eligible set SHALL be req_i & ~gnt_o; a requester granted in the current cycle is excluded for that cycle.
REQ-021 If the eligible set is nonzero in RUN, the winner SHALL be chosen round-robin.
  - Search starts at index ptr and wraps NUM_REQ-1 -> 0.
  - At the next edge: gnt_o = one-hot(winner), S = next(S), data_o = next(S)[7:0], ptr = (winner+1) mod NUM_REQ.
REQ-022 Latency from request to grant SHALL be 1 cycle minimum.
REQ-023 gnt_o SHALL be high for exactly one cycle per grant; the requester is expected to drop req_i the cycle after seeing gnt_o.
REQ-024 With an empty eligible set, or outside RUN, the next gnt_o SHALL be 0, S SHALL be unchanged (except in WARMUP), and data_o SHALL hold its last value.
REQ-025 S SHALL advance exactly once per grant, so the byte sequence is deterministic per seed regardless of which requester is served.
REQ-026 seed_load_i sampled high in any state SHALL take priority over everything else.
  - Effects at that edge: S = seed_i (zero-substituted), warmup counter cleared, state = WARMUP, gnt_o = 0, ptr unchanged.
  - Any grant that would have issued that cycle is dropped.
REQ-027 Simultaneous seed_load_i and enable_i low SHALL reseed first; the RUN/HOLD choice is made at warmup end.

Reset
REQ-028 When rst_i is sampled high, the block SHALL set: S = SEED (zero-substituted), state = WARMUP, warmup counter = 0, ptr = 0, gnt_o = 0, data_o = 8'h00, ready_o = 0.
REQ-029 rst_i SHALL override seed_load_i and enable_i.
REQ-030 Reset asserted mid-operation SHALL abort any pending grant with no gnt_o pulse.

Verification
REQ-031 Reset value check: SEED=1, WARMUP_CYCLES=0, enable_i=1, rst_i pulse, then req_i=4'b0001 -> next cycle gnt_o=4'b0001, data_o=8'h21 (S=32'h0004_2021).
REQ-032 Round-robin check: req_i=4'b1111 held constant in RUN from ptr=0 -> gnt_o sequence 0001, 0010, 0100, 1000, 0001, with no idle cycles and no repeat grants.
REQ-033 Zero-seed check: seed_load_i=1 with seed_i=0, WARMUP_CYCLES=0 -> S=32'hDEADBEEF; the first grant's data_o equals next(32'hDEADBEEF)[7:0] from the reference model.
REQ-034 Warmup check: WARMUP_CYCLES=8 with req_i=4'b0001 high from reset -> ready_o and gnt_o held 0 for 8 cycles, first grant data_o = next^9(SEED)[7:0].
REQ-035 Reseed-mid-run check: req_i=4'b0011 in RUN, with seed_load_i asserted on the cycle a grant is due -> no gnt_o that cycle, ready_o=0 through warmup, byte sequence restarts from the new seed.
REQ-036 HOLD check: enable_i=0 in RUN with requests pending -> gnt_o=0 and data_o held; on enable_i=1, grants resume from the saved ptr with the next byte of the uninterrupted sequence.

Source files
------------

// File: rtl/prng_arbiter.sv
// Round-robin arbiter whose grants each carry one byte from a 32-bit xorshift generator.
// The byte stream depends only on the seed and the number of grants, not on who is served.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_WARMUP | generator free-runs WARMUP_CYCLES steps after seeding, no grants
// ST_RUN    | arbitration active, ready_o high
// ST_HOLD   | enable_i low: generator frozen, no grants, pointer retained

module prng_arbiter #(
    parameter int          NUM_REQ       = 4,
    parameter logic [31:0] SEED          = 32'h0000_0001,
    parameter int          WARMUP_CYCLES = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               enable_i,
    input  logic               seed_load_i,
    input  logic [31:0]        seed_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [7:0]         data_o,
    output logic               ready_o
);

    localparam int          PW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [31:0] ZERO_SUB  = 32'hDEAD_BEEF;
    localparam logic [31:0] SEED_INIT = (SEED == 32'h0) ? ZERO_SUB : SEED;
    localparam logic [7:0]  WARM_LAST = 8'(WARMUP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_RUN    = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    function automatic logic [31:0] xs_next(input logic [31:0] s);
        logic [31:0] t;
        t = s ^ (s << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    state_t             state_q, state_d;
    logic [31:0]        s_q, s_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [7:0]         data_q, data_d;

    logic [31:0]        s_adv;
    logic [NUM_REQ-1:0] elig;
    logic               found;
    logic [PW-1:0]      win;

    assign s_adv = xs_next(s_q);
    assign elig  = req_i & ~gnt_q;

    // First eligible requester at or after ptr, wrapping at NUM_REQ.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && elig[PW'(idx)]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        data_d  = data_q;
        if (seed_load_i) begin
            s_d     = (seed_i == 32'h0) ? ZERO_SUB : seed_i;
            cnt_d   = '0;
            state_d = ST_WARMUP;
        end else begin
            unique case (state_q)
                ST_WARMUP: begin
                    if (WARMUP_CYCLES == 0) begin
                        state_d = enable_i ? ST_RUN : ST_HOLD;
                    end else begin
                        s_d   = s_adv;
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q == WARM_LAST) begin
                            state_d = enable_i ? ST_RUN : ST_HOLD;
                        end
                    end
                end
                ST_RUN: begin
                    if (!enable_i) begin
                        state_d = ST_HOLD;
                    end else if (found) begin
                        gnt_d  = NUM_REQ'(1) << win;
                        s_d    = s_adv;
                        data_d = s_adv[7:0];
                        ptr_d  = (win == PW'(NUM_REQ - 1)) ? '0 : win + PW'(1);
                    end
                end
                ST_HOLD: begin
                    if (enable_i) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_WARMUP;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_WARMUP;
            s_q     <= SEED_INIT;
            cnt_q   <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            data_q  <= data_d;
        end
    end

    assign gnt_o   = gnt_q;
    assign data_o  = data_q;
    assign ready_o = (state_q == ST_RUN);

endmodule
